// File: rtl/cpu_alu_arb.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters, with per-requester flag registers.
// Latency: handshake -> resp_valid after EXEC_CYC (MUL_CYC for multiply) edges; no backpressure on responses.
module cpu_alu_arb #(
  parameter int N_REQ    = 2,
  parameter int EXEC_CYC = 1,
  parameter int MUL_CYC  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  input  logic [N_REQ*8-1:0]   req_op,
  input  logic [N_REQ-1:0]     flag_clr,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [7:0]           alu_op,
  input  logic [31:0]          alu_out,
  input  logic [3:0]           alu_flags,
  input  logic [3:0]           alu_flag_en,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [31:0]          resp_out,
  output logic [N_REQ*4-1:0]   flags_q,
  output logic                 busy
);
  localparam int PW = (N_REQ > 2) ? 2 : 1;
  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [PW:0] L_NREQ = (PW+1)'(N_REQ);

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  state_t r_state, w_state_nxt;

  logic [PW-1:0]      r_ptr, r_owner;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_alu_a, r_alu_b, r_resp_out;
  logic [7:0]         r_alu_op;
  logic [N_REQ-1:0]   r_resp_vld;
  logic [N_REQ*4-1:0] r_flags;

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot, w_gnt_oh, w_own_oh;
  logic               w_found, w_hs, w_cap, w_mul;
  logic [PW-1:0]      w_off, w_grant, w_gnext;
  logic [PW:0]        w_sum, w_sum1;
  logic [31:0]        w_a, w_b;
  logic [7:0]         w_op;

  // Rotate valids so that bit 0 is the requester at ptr, then take the lowest set bit.
  assign w_dbl = {req_valid, req_valid} >> r_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = PW'(i);
      end
    end
  end

  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_grant  = (w_sum >= L_NREQ) ? PW'(w_sum - L_NREQ) : w_sum[PW-1:0];
  assign w_sum1   = {1'b0, w_grant} + 1'b1;
  assign w_gnext  = (w_sum1 == L_NREQ) ? '0 : w_sum1[PW-1:0];
  assign w_gnt_oh = N_REQ'(1) << w_grant;
  assign w_own_oh = N_REQ'(1) << r_owner;

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == PW'(i)) begin
        w_a  = req_a[32*i +: 32];
        w_b  = req_b[32*i +: 32];
        w_op = req_op[8*i +: 8];
      end
    end
  end

  assign w_mul = w_op[4] & w_op[2];
  assign w_hs  = (r_state == S_IDLE) && w_found;
  assign w_cap = (r_state == S_EXEC) && (r_cnt == '0);

  assign req_ready  = (w_hs ? w_gnt_oh : '0) & {N_REQ{rst_n}};
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign resp_valid = r_resp_vld;
  assign resp_out   = r_resp_out;
  assign flags_q    = r_flags;
  assign busy       = (r_state == S_EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
      S_EXEC:  if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_resp_out <= '0;
      r_resp_vld <= '0;
    end else begin
      r_resp_vld <= '0;
      if (w_hs) begin
        r_alu_a  <= w_a;
        r_alu_b  <= w_b;
        r_alu_op <= w_op;
        r_owner  <= w_grant;
        r_ptr    <= w_gnext;
        r_cnt    <= w_mul ? CW'(MUL_CYC-1) : CW'(EXEC_CYC-1);
      end else if (w_cap) begin
        r_resp_out <= alu_out;
        r_resp_vld <= w_own_oh;
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Clear takes precedence over a coincident flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (flag_clr[i])
          r_flags[4*i +: 4] <= 4'b0;
        else if (w_cap && r_owner == PW'(i))
          r_flags[4*i +: 4] <= (r_flags[4*i +: 4] & ~alu_flag_en) | (alu_flags & alu_flag_en);
      end
    end
  end
endmodule
